// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: walks FETCH/DECODE/EXECUTE/MEM/WB per opcode
// and decodes the datapath strobes from the current state.
module instruction_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       pc_write_en,
    output logic [1:0] pc_src,
    output logic       ir_write_en,
    output logic       mem_read,
    output logic       mem_write,
    output logic       mem_addr_sel,
    output logic       reg_write_en,
    output logic [1:0] wb_sel,
    output logic [2:0] state,
    output logic       illegal
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM_RD  = 3'd3,
        S_MEM_WR  = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd7
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_illegal;
    logic   w_legal;

    always_comb begin
        case (opcode)
            OPC_LOAD, OPC_STORE, OPC_OP, OPC_OPIMM, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH: w_legal = 1'b1;
            default:                                  w_legal = 1'b0;
        endcase
    end

    // State register; illegal stays set until reset since HALT only exits via rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_illegal <= r_illegal | (w_next == S_HALT);
        end
    end

    // Next state and state-decoded strobes; everything held quiet during reset.
    always_comb begin
        w_next       = r_state;
        pc_write_en  = 1'b0;
        pc_src       = PC_PLUS4;
        ir_write_en  = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr_sel = 1'b0;
        reg_write_en = 1'b0;
        wb_sel       = WB_ALU;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write_en = 1'b1;
                        w_next      = S_DECODE;
                    end
                end
                S_DECODE: w_next = w_legal ? S_EXECUTE : S_HALT;
                S_EXECUTE: begin
                    case (opcode)
                        OPC_LOAD:  w_next = S_MEM_RD;
                        OPC_STORE: w_next = S_MEM_WR;
                        OPC_BRANCH: begin
                            w_next      = S_FETCH;
                            pc_write_en = 1'b1;
                            pc_src      = branch_taken ? PC_IMM : PC_PLUS4;
                        end
                        default:   w_next = S_WB;
                    endcase
                end
                S_MEM_RD: begin
                    mem_read     = 1'b1;
                    mem_addr_sel = 1'b1;
                    if (mem_ready) w_next = S_WB;
                end
                S_MEM_WR: begin
                    mem_write    = 1'b1;
                    mem_addr_sel = 1'b1;
                    if (mem_ready) begin
                        pc_write_en = 1'b1;
                        w_next      = S_FETCH;
                    end
                end
                S_WB: begin
                    reg_write_en = 1'b1;
                    pc_write_en  = 1'b1;
                    w_next       = S_FETCH;
                    case (opcode)
                        OPC_LOAD: wb_sel = WB_MEM;
                        OPC_JAL: begin
                            wb_sel = WB_PC4;
                            pc_src = PC_IMM;
                        end
                        OPC_JALR: begin
                            wb_sel = WB_PC4;
                            pc_src = PC_ALU;
                        end
                        default: wb_sel = WB_ALU;
                    endcase
                end
                S_HALT:  w_next = S_HALT;
                default: w_next = S_FETCH;
            endcase
        end
    end

    assign state   = rst ? 3'd0 : r_state;
    assign illegal = r_illegal & ~rst;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized self-checking bench: an instruction-level model expands each opcode
// into its expected per-cycle trace, which is compared against the DUT outputs.
module tb_instruction_sequencer;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       branch_taken;
    logic       mem_ready;
    logic       pc_write_en;
    logic [1:0] pc_src;
    logic       ir_write_en;
    logic       mem_read;
    logic       mem_write;
    logic       mem_addr_sel;
    logic       reg_write_en;
    logic [1:0] wb_sel;
    logic [2:0] state;
    logic       illegal;

    instruction_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .pc_write_en  (pc_write_en),
        .pc_src       (pc_src),
        .ir_write_en  (ir_write_en),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr_sel (mem_addr_sel),
        .reg_write_en (reg_write_en),
        .wb_sel       (wb_sel),
        .state        (state),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       mas;
        logic       rwe;
        logic [1:0] wbs;
        logic       ill;
    } vec_t;

    typedef struct {
        logic       mr;
        logic [6:0] op;
        logic       bt;
        vec_t       e;
    } step_t;

    step_t q[$];
    int    n_checks;
    int    n_errors;
    int    pcw_cnt;
    int    cyc;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got=%h expected=%h", tag, cyc, got, want);
        end
    endtask

    function automatic vec_t observe();
        return vec_t'({state, pc_write_en, pc_src, ir_write_en, mem_read, mem_write,
                       mem_addr_sel, reg_write_en, wb_sel, illegal});
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        return op inside {LOAD, STORE, OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH};
    endfunction

    task automatic push(input logic mr, input logic [6:0] op, input logic bt, input vec_t e);
        step_t s;
        s.mr = mr; s.op = op; s.bt = bt; s.e = e;
        q.push_back(s);
    endtask

    // Expected trace of one instruction: wf fetch stalls, wm memory-phase stalls.
    task automatic gen(input logic [6:0] op, input logic bt, input int wf, input int wm);
        vec_t e;
        for (int i = 0; i < wf; i++) begin
            e = '0; e.st = 3'd0; e.mrd = 1'b1;
            push(1'b0, 7'($urandom), 1'($urandom), e);
        end
        e = '0; e.st = 3'd0; e.mrd = 1'b1; e.irw = 1'b1;
        push(1'b1, op, 1'($urandom), e);
        e = '0; e.st = 3'd1;
        push(1'($urandom), op, 1'($urandom), e);
        if (!is_legal(op)) begin
            for (int i = 0; i < 10; i++) begin
                e = '0; e.st = 3'd7; e.ill = 1'b1;
                push(1'($urandom), op, 1'($urandom), e);
            end
            return;
        end
        e = '0; e.st = 3'd2;
        if (op == BRANCH) begin
            e.pcw = 1'b1; e.pcs = bt ? 2'b01 : 2'b00;
            push(1'($urandom), op, bt, e);
            return;
        end
        push(1'($urandom), op, 1'($urandom), e);
        if (op == LOAD) begin
            for (int i = 0; i <= wm; i++) begin
                e = '0; e.st = 3'd3; e.mrd = 1'b1; e.mas = 1'b1;
                push(i == wm, op, 1'($urandom), e);
            end
        end
        if (op == STORE) begin
            for (int i = 0; i <= wm; i++) begin
                e = '0; e.st = 3'd4; e.mwr = 1'b1; e.mas = 1'b1;
                e.pcw = (i == wm);
                push(i == wm, op, 1'($urandom), e);
            end
            return;
        end
        e = '0; e.st = 3'd5; e.rwe = 1'b1; e.pcw = 1'b1;
        e.wbs = (op == LOAD) ? 2'b01 : (op == JAL || op == JALR) ? 2'b10 : 2'b00;
        e.pcs = (op == JAL) ? 2'b01 : (op == JALR) ? 2'b10 : 2'b00;
        push(1'($urandom), op, 1'($urandom), e);
    endtask

    // Plays n queued steps (all if n<0); entered and left just after a rising edge.
    task automatic run(input int n);
        step_t s;
        int    k;
        k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            s = q.pop_front();
            mem_ready = s.mr; opcode = s.op; branch_taken = s.bt;
            @(negedge clk);
            check_eq("trace", 16'(observe()), 16'(s.e));
            if (pc_write_en) pcw_cnt++;
            @(posedge clk); #1;
            cyc++;
            k++;
        end
    endtask

    task automatic do_instr(input logic [6:0] op, input logic bt, input int wf, input int wm);
        pcw_cnt = 0;
        gen(op, bt, wf, wm);
        run(-1);
        check_eq("pcw_once", 16'(pcw_cnt), 16'd1);
    endtask

    task automatic reset_pulse(input string tag);
        q.delete();
        rst = 1'b1; mem_ready = 1'($urandom); opcode = 7'($urandom);
        @(negedge clk);
        check_eq(tag, 16'(observe()), 16'd0);
        @(posedge clk); #1;
        cyc++;
        rst = 1'b0;
    endtask

    logic [6:0] legal_ops [9];
    logic [6:0] bad;

    initial begin
        legal_ops = '{LOAD, STORE, OP, OPIMM, LUI, AUIPC, JAL, JALR, BRANCH};
        n_checks = 0; n_errors = 0; pcw_cnt = 0; cyc = 0;
        rst = 1'b1; opcode = '0; branch_taken = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) reset_pulse("reset_quiet");

        do_instr(OP, 1'b0, 0, 0);
        do_instr(LOAD, 1'b0, 0, 2);
        do_instr(BRANCH, 1'b1, 0, 0);
        do_instr(BRANCH, 1'b0, 0, 0);
        do_instr(JALR, 1'b0, 0, 0);
        do_instr(JAL, 1'b0, 0, 0);
        do_instr(STORE, 1'b0, 1, 1);

        for (int i = 0; i < 60; i++)
            do_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom),
                     $urandom_range(0, 2), $urandom_range(0, 3));

        // Reset while a store waits on memory: no write/PC pulse, restart at FETCH.
        pcw_cnt = 0;
        gen(STORE, 1'b0, 0, 5);
        run(5);
        check_eq("abort_state", 16'(state), 16'd4);
        reset_pulse("rst_in_memwr");
        check_eq("abort_pcw", 16'(pcw_cnt), 16'd0);
        do_instr(OP, 1'b0, 0, 0);

        // Illegal opcodes lock into HALT until reset.
        for (int j = 0; j < 2; j++) begin
            if (j == 0) bad = 7'h7F;
            else begin
                bad = 7'($urandom);
                while (is_legal(bad)) bad = 7'($urandom);
            end
            pcw_cnt = 0;
            gen(bad, 1'b0, j, 0);
            run(-1);
            check_eq("halt_pcw", 16'(pcw_cnt), 16'd0);
            reset_pulse("rst_in_halt");
            do_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom), 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Request qualifiers must never overlap.
    always @(negedge clk) begin
        if (mem_read && mem_write)
            check_eq("rd_wr_excl", 16'({mem_read, mem_write}), 16'd0);
    end

endmodule
